// File: rtl/multi_debouncer.sv
// multi_debouncer: CHANNELS independent debouncers. Each channel changes its
// registered output only after STABLE_CYCLES consecutive samples that differ
// from it. Each change raises a one-cycle rise or fall pulse.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer on every
// input bit. This adds 2 cycles of latency and delays the initial capture to
// the 3rd edge after reset.
// Reset is synchronous and active-high on port reset.
module multi_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int CNT_W         = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_STABLE,
    ST_COUNTING
  } state_t;

  // The counter value reached just before the final confirming sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // With a one-sample threshold there is nothing to count.
  localparam bit SINGLE_SAMPLE = (STABLE_CYCLES == 1);

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] out_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] sample;
  logic                capture_en;

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [1:0]          warm_q;

  // Two-flop synchronizer, plus a warm-up count that holds INIT until valid data leaves the synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
    end
  end

  assign sample     = sync2_q;
  assign capture_en = (warm_q == 2'd2);
`else
  assign sample     = sig_in;
  assign capture_en = 1'b1;
`endif

  // Per-channel next-state, counter, output level and edge pulses.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    out_d  = sig_out;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_INIT: begin
          if (capture_en) begin
            out_d[i]   = sample[i];
            cnt_d[i]   = '0;
            state_d[i] = ST_STABLE;
          end
        end
        ST_STABLE: begin
          cnt_d[i] = '0;
          if (sample[i] != sig_out[i]) begin
            if (SINGLE_SAMPLE) begin
              out_d[i]  = sample[i];
              rise_d[i] = sample[i];
              fall_d[i] = ~sample[i];
            end else begin
              cnt_d[i]   = CNT_W'(1);
              state_d[i] = ST_COUNTING;
            end
          end
        end
        ST_COUNTING: begin
          if (sample[i] == sig_out[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_STABLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            out_d[i]   = sample[i];
            rise_d[i]  = sample[i];
            fall_d[i]  = ~sample[i];
            cnt_d[i]   = '0;
            state_d[i] = ST_STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = ST_INIT;
        end
      endcase
    end
  end

  // State, counter and output registers; reset discards any count in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_INIT;
        cnt_q[i]   <= '0;
      end
      sig_out <= '0;
      rise    <= '0;
      fall    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sig_out <= out_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // busy: any channel part-way through confirming a change.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy = busy | (cnt_q[i] != '0);
    end
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: number of independent debounce channels, legal range 1..32.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the per-channel stability counter.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 3: consecutive differing samples required to change an output, legal range 1..(2^CNT_W)-1.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port sig_in, input, CHANNELS bits: raw bouncing inputs, one bit per channel.
REQ-007 The block SHALL have port sig_out, output, CHANNELS bits: registered debounced levels.
REQ-008 The block SHALL have port rise, output, CHANNELS bits: one-cycle pulse when sig_out[i] goes 0->1.
REQ-009 The block SHALL have port fall, output, CHANNELS bits: one-cycle pulse when sig_out[i] goes 1->0.
REQ-010 The block SHALL have port busy, output, 1 bit: high when any channel counter is non-zero.

Function
REQ-011 Each channel SHALL use an independent FSM with states INIT, STABLE and COUNTING, plus a CNT_W-bit counter cnt[i].
REQ-012 INIT SHALL load sig_out[i] from the sampled input without debouncing, on the single cycle after reset deasserts, then go to STABLE; rise[i] and fall[i] stay 0.
REQ-013 STABLE SHALL stay in STABLE with cnt=0 when sample==sig_out[i]; when sample!=sig_out[i] it SHALL set cnt=1 and go to COUNTING.
REQ-014 COUNTING SHALL clear cnt and return to STABLE without an output change when sample==sig_out[i].
REQ-015 COUNTING SHALL increment cnt when sample!=sig_out[i] and cnt+1<STABLE_CYCLES.
REQ-016 COUNTING SHALL toggle sig_out[i], clear cnt, go to STABLE, and assert the matching rise[i]/fall[i] for exactly that one cycle when sample!=sig_out[i] and cnt+1==STABLE_CYCLES.
REQ-017 For STABLE_CYCLES==1, STABLE SHALL toggle directly on the first differing sample, bypass COUNTING, and give 1-cycle latency.
REQ-018 Latency SHALL be: sig_out changes on the clock edge that captures the STABLE_CYCLES-th consecutive differing sample.
REQ-019 rise[i] and fall[i] SHALL be registered, coincide with the sig_out[i] update, and never be high simultaneously.
REQ-020 A single-cycle glitch, or any run shorter than STABLE_CYCLES, SHALL produce no change in sig_out, rise or fall.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.
REQ-022 busy SHALL be combinational OR of (cnt[i]!=0) over all channels.
REQ-023 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-024 While reset is high, all channels SHALL be in INIT, cnt=0, and sig_out=0, rise=0, fall=0, busy=0.
REQ-025 Reset asserted mid-count SHALL discard the count on the next edge; no pulse SHALL be emitted for the aborted transition.

Configuration
REQ-026 With macro DEBOUNCE_SYNC_EN defined, each sig_in bit SHALL pass through a 2-flop synchronizer (reset to 0) before the FSM, adding 2 cycles of latency, and INIT SHALL capture on the 3rd edge after reset deasserts.
REQ-027 Without DEBOUNCE_SYNC_EN, the FSM SHALL sample sig_in directly, and INIT SHALL capture on the 1st edge after reset deasserts.

Verification (CHANNELS=4, STABLE_CYCLES=3, macro undefined unless stated)
REQ-028 Bench SHALL cover: reset with sig_in=4'b1010, then release -> sig_out=4'b1010 one edge later, rise=fall=0.
REQ-029 Bench SHALL cover: ch0 held 0 then 1 steadily -> sig_out[0]=1 and rise[0]=1 for one cycle on the 3rd edge sampling 1; busy high for the 2 preceding cycles.
REQ-030 Bench SHALL cover: ch1 bounce pattern 1,0,1,1,0 from a stable 0 -> sig_out[1] stays 0, no pulses, busy returns low.
REQ-031 Bench SHALL cover: ch2 and ch3 both held changed for 3 cycles simultaneously -> both update and both pulse on the same edge.
REQ-032 Bench SHALL cover: reset asserted after 2 differing samples on ch0 -> sig_out=0, no rise, cnt=0.
REQ-033 Bench SHALL cover, with DEBOUNCE_SYNC_EN: a step on ch0 -> sig_out[0] changes 5 edges after the step.
